scoreboard_bypass: RTL

- Parametrised successor to the fixed 4-operand forwarding mux.
- Holds its own in-flight destination tracker: a shift register of destinations, one slot per lane per post-issue stage.
- Each cycle it resolves every source operand to the youngest in-flight producer, the register-file value, or a load-use stall.
- Sits between issue and operand read in the multi-issue MIPS pipeline; consumes stage results from execute through commit.

---
 rtl/scoreboard_bypass.sv | 105 ++++++++++
 1 files changed

// File: rtl/scoreboard_bypass.sv
// In-flight destination tracker with operand bypass resolution for a multi-issue pipeline.
// Each source resolves to the youngest producer, the register file, or a load-use stall.
module scoreboard_bypass #(
  parameter int ISSUE_WIDTH  = 2,
  parameter int SRC_PER_LANE = 2,
  parameter int DEPTH        = 3,
  parameter int REG_ADDR_W   = 5,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    advance,
  input  logic                                                    flush,
  input  logic [ISSUE_WIDTH-1:0]                                  issue_valid,
  input  logic [ISSUE_WIDTH-1:0][REG_ADDR_W-1:0]                  issue_dst,
  input  logic [ISSUE_WIDTH-1:0]                                  issue_late,
  input  logic [ISSUE_WIDTH-1:0][SRC_PER_LANE-1:0][REG_ADDR_W-1:0] src_reg,
  input  logic [ISSUE_WIDTH-1:0][SRC_PER_LANE-1:0][DATA_WIDTH-1:0] rf_data,
  input  logic [DEPTH-1:0][ISSUE_WIDTH-1:0][DATA_WIDTH-1:0]        stage_result,
  output logic [ISSUE_WIDTH-1:0][SRC_PER_LANE-1:0][DATA_WIDTH-1:0] operand,
  output logic [ISSUE_WIDTH-1:0][SRC_PER_LANE-1:0]                 src_stall,
  output logic                                                    stall,
  output logic [DEPTH-1:0][ISSUE_WIDTH-1:0]                        busy
);

  logic [DEPTH-1:0][ISSUE_WIDTH-1:0]                 valid_reg, valid_next;
  logic [DEPTH-1:0][ISSUE_WIDTH-1:0]                 late_reg, late_next;
  logic [DEPTH-1:0][ISSUE_WIDTH-1:0][REG_ADDR_W-1:0] dst_reg, dst_next;

  always_comb begin
    valid_next = valid_reg;
    late_next  = late_reg;
    dst_next   = dst_reg;
    if (flush) begin
      // Without advance the commit stage has already passed the point of no return.
      for (int s = 0; s < DEPTH; s++) begin
        if (advance || (s != DEPTH - 1)) begin
          valid_next[s] = '0;
          late_next[s]  = '0;
          dst_next[s]   = '0;
        end
      end
    end else if (advance) begin
      for (int s = DEPTH - 1; s > 0; s--) begin
        valid_next[s] = valid_reg[s-1];
        late_next[s]  = late_reg[s-1];
        dst_next[s]   = dst_reg[s-1];
      end
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        valid_next[0][l] = issue_valid[l] && (issue_dst[l] != '0);
        late_next[0][l]  = issue_late[l];
        dst_next[0][l]   = issue_dst[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      late_reg  <= '0;
      dst_reg   <= '0;
    end else begin
      valid_reg <= valid_next;
      late_reg  <= late_next;
      dst_reg   <= dst_next;
    end
  end

  genvar gi, gk;
  generate
    for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : lane_g
      for (gk = 0; gk < SRC_PER_LANE; gk++) begin : src_g
        logic                  hit;
        logic                  hit_late;
        logic [DATA_WIDTH-1:0] hit_data;
        logic                  is_zero;

        // Scan oldest to youngest so the last match written is the youngest producer.
        always_comb begin
          hit      = 1'b0;
          hit_late = 1'b0;
          hit_data = '0;
          for (int s = DEPTH - 1; s >= 0; s--) begin
            for (int j = 0; j < ISSUE_WIDTH; j++) begin
              if (valid_reg[s][j] && (dst_reg[s][j] == src_reg[gi][gk])) begin
                hit      = 1'b1;
                hit_late = late_reg[s][j] && (s == 0);
                hit_data = stage_result[s][j];
              end
            end
          end
        end

        assign is_zero            = (src_reg[gi][gk] == '0);
        assign src_stall[gi][gk]  = !is_zero && hit && hit_late;
        assign operand[gi][gk]    = (is_zero || (hit && hit_late)) ? '0 :
                                    hit ? hit_data : rf_data[gi][gk];
      end
    end
  endgenerate

  assign stall = |src_stall;
  assign busy  = valid_reg;

endmodule
